fp_regfile_ctrl: RTL and testbench

Floating-point register file and operand-hazard control that sits directly upstream of the FP execute pipeline.
- Holds 32 x 32-bit FP registers, written from the FP writeback stage (wn/wd/ww).
- Supplies the two source operands a/b with forwarding from the E3 result (ed) and the writeback result (wd).
- Raises an interlock stall when a source register is still being produced in E1 or E2.
- Keeps a saturating stall-cycle counter for performance monitoring.

---
 rtl/fp_regfile_ctrl.sv | 119 +++++++++++
 tb/tb_fp_regfile_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/fp_regfile_ctrl.sv
// FP register file with E3/WB operand forwarding and E1/E2 interlock detection.
// Keeps a saturating count of stalled cycles for performance monitoring.
module fp_regfile_ctrl #(
  parameter int NREG = 32,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            clrn,
  input  logic [4:0]      fs,
  input  logic [4:0]      ft,
  input  logic            fs_use,
  input  logic            ft_use,
  input  logic            e1w,
  input  logic [4:0]      e1n,
  input  logic            e2w,
  input  logic [4:0]      e2n,
  input  logic            e3w,
  input  logic [4:0]      e3n,
  input  logic [31:0]     ed,
  input  logic            ww,
  input  logic [4:0]      wn,
  input  logic [31:0]     wd,
  output logic [31:0]     a,
  output logic [31:0]     b,
  output logic [1:0]      fwda,
  output logic [1:0]      fwdb,
  output logic            stall_fp,
  output logic [CNTW-1:0] stall_cnt
);

  logic [31:0]     regs_r [NREG];
  logic [CNTW-1:0] stall_cnt_r;
  logic            hazard_a_s;
  logic            hazard_b_s;
  logic [1:0]      fwda_s;
  logic [1:0]      fwdb_s;

  // Youngest producer still in flight wins: E3 beats WB, WB beats the array.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic e3_we,
                                         input logic [4:0] e3_num, input logic wb_we,
                                         input logic [4:0] wb_num);
    logic [1:0] sel;
    if (e3_we && (e3_num == src)) begin
      sel = 2'd2;
    end else if (wb_we && (wb_num == src)) begin
      sel = 2'd1;
    end else begin
      sel = 2'd0;
    end
    return sel;
  endfunction

  function automatic logic hazard(input logic src_use, input logic [4:0] src,
                                  input logic w1, input logic [4:0] n1,
                                  input logic w2, input logic [4:0] n2);
    return src_use & ((w1 & (n1 == src)) | (w2 & (n2 == src)));
  endfunction

  // Register array: async clear, written from writeback independent of stalls.
  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= 32'd0;
      end
    end else if (ww) begin
      regs_r[wn] <= wd;
    end else begin
      regs_r[wn] <= regs_r[wn];
    end
  end

  // Forwarding select and interlock detection for both sources.
  always_comb begin
    fwda_s     = fwd_sel(fs, e3w, e3n, ww, wn);
    fwdb_s     = fwd_sel(ft, e3w, e3n, ww, wn);
    hazard_a_s = hazard(fs_use, fs, e1w, e1n, e2w, e2n);
    hazard_b_s = hazard(ft_use, ft, e1w, e1n, e2w, e2n);
  end

  // Operand a mux.
  always_comb begin
    a = regs_r[fs];
    case (fwda_s)
      2'd2:    a = ed;
      2'd1:    a = wd;
      2'd0:    a = regs_r[fs];
      default: a = regs_r[fs];
    endcase
  end

  // Operand b mux.
  always_comb begin
    b = regs_r[ft];
    case (fwdb_s)
      2'd2:    b = ed;
      2'd1:    b = wd;
      2'd0:    b = regs_r[ft];
      default: b = regs_r[ft];
    endcase
  end

  assign fwda     = fwda_s;
  assign fwdb     = fwdb_s;
  assign stall_fp = hazard_a_s | hazard_b_s;

  // Stall-cycle counter; holds at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      stall_cnt_r <= {CNTW{1'b0}};
    end else if (stall_fp && (stall_cnt_r != {CNTW{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + {{(CNTW-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_fp_regfile_ctrl.sv
// Directed plus randomized checks of fp_regfile_ctrl against a behavioural model.
// The DUT uses a 4-bit stall counter so saturation is reachable quickly.
module tb_fp_regfile_ctrl;

  localparam int CNTW = 4;
  localparam int CMAX = 15;

  logic            clk;
  logic            clrn;
  logic [4:0]      fs, ft, e1n, e2n, e3n, wn;
  logic            fs_use, ft_use, e1w, e2w, e3w, ww;
  logic [31:0]     ed, wd;
  logic [31:0]     a, b;
  logic [1:0]      fwda, fwdb;
  logic            stall_fp;
  logic [CNTW-1:0] stall_cnt;

  int          total;
  int          bad;
  logic [31:0] mregs [32];
  int          mcnt;
  logic        exp_stall;

  fp_regfile_ctrl #(.NREG(32), .CNTW(CNTW)) dut (
    .clk(clk), .clrn(clrn), .fs(fs), .ft(ft), .fs_use(fs_use), .ft_use(ft_use),
    .e1w(e1w), .e1n(e1n), .e2w(e2w), .e2n(e2n), .e3w(e3w), .e3n(e3n), .ed(ed),
    .ww(ww), .wn(wn), .wd(wd), .a(a), .b(b), .fwda(fwda), .fwdb(fwdb),
    .stall_fp(stall_fp), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: who produces src this cycle, in youngest-first order.
  task automatic model_src(input logic [4:0] src, input logic src_use,
                           output logic [31:0] v, output logic [1:0] f, output logic hz);
    hz = src_use && ((e1w && e1n == src) || (e2w && e2n == src));
    if (e3w && e3n == src) begin
      v = ed; f = 2'd2;
    end else if (ww && wn == src) begin
      v = wd; f = 2'd1;
    end else begin
      v = mregs[src]; f = 2'd0;
    end
  endtask

  task automatic settle();
    logic [31:0] va, vb;
    logic [1:0]  fa, fb;
    logic        ha, hb;
    @(negedge clk);
    model_src(fs, fs_use, va, fa, ha);
    model_src(ft, ft_use, vb, fb, hb);
    exp_stall = ha || hb;
    chk("a", a, va);
    chk("b", b, vb);
    chk("fwda", {30'd0, fwda}, {30'd0, fa});
    chk("fwdb", {30'd0, fwdb}, {30'd0, fb});
    chk("stall_fp", {31'd0, stall_fp}, {31'd0, exp_stall});
    chk("stall_cnt", {28'd0, stall_cnt}, mcnt);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!clrn) begin
      if (exp_stall && mcnt < CMAX) mcnt++;
      if (ww) mregs[wn] = wd;
    end
    #1;
  endtask

  task automatic idle();
    fs = 5'd0; ft = 5'd0; fs_use = 1'b0; ft_use = 1'b0;
    e1w = 1'b0; e1n = 5'd0; e2w = 1'b0; e2n = 5'd0; e3w = 1'b0; e3n = 5'd0;
    ed = 32'd0; ww = 1'b0; wn = 5'd0; wd = 32'd0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    mcnt = 0;
  endtask

  initial begin
    total = 0; bad = 0; exp_stall = 1'b0;
    model_clear();
    idle();
    clrn = 1'b1;
    #12;
    @(posedge clk); #1;
    clrn = 1'b0;

    // Reset state
    fs = 5'd5; ft = 5'd31;
    settle();
    chk("rst_a", a, 32'd0); chk("rst_b", b, 32'd0);
    chk("rst_cnt", {28'd0, stall_cnt}, 32'd0);
    tick();

    // Write-through in the write cycle, then plain read
    idle(); ww = 1'b1; wn = 5'd3; wd = 32'h3F80_0000; fs = 5'd3;
    settle();
    chk("wt_a", a, 32'h3F80_0000); chk("wt_fwda", {30'd0, fwda}, 32'd1);
    tick();
    idle(); fs = 5'd3;
    settle();
    chk("rd_a", a, 32'h3F80_0000); chk("rd_fwda", {30'd0, fwda}, 32'd0);
    tick();

    // E3 beats WB to the same register
    idle(); e3w = 1'b1; e3n = 5'd7; ed = 32'h4049_0FDB;
    ww = 1'b1; wn = 5'd7; wd = 32'h1111_1111; fs = 5'd7; fs_use = 1'b1;
    settle();
    chk("e3_a", a, 32'h4049_0FDB); chk("e3_fwda", {30'd0, fwda}, 32'd2);
    chk("e3_stall", {31'd0, stall_fp}, 32'd0);
    tick();

    // Producer of f4 walks E1 -> E2 -> E3 while consumer waits
    idle(); ft = 5'd4; ft_use = 1'b1; e1w = 1'b1; e1n = 5'd4;
    settle(); chk("il_e1", {31'd0, stall_fp}, 32'd1); tick();
    idle(); ft = 5'd4; ft_use = 1'b1; e2w = 1'b1; e2n = 5'd4;
    settle(); chk("il_e2", {31'd0, stall_fp}, 32'd1); tick();
    idle(); ft = 5'd4; ft_use = 1'b1; e3w = 1'b1; e3n = 5'd4; ed = 32'hC0DE_0004;
    settle();
    chk("il_e3_stall", {31'd0, stall_fp}, 32'd0);
    chk("il_e3_fwdb", {30'd0, fwdb}, 32'd2);
    chk("il_e3_b", b, 32'hC0DE_0004);
    chk("il_cnt", {28'd0, stall_cnt}, 32'd2);
    tick();

    // fs_use gates the stall, fs==ft resolves identically
    idle(); e1w = 1'b1; e1n = 5'd9; fs = 5'd9; ft = 5'd9;
    settle(); chk("use_gate", {31'd0, stall_fp}, 32'd0); tick();
    settle(); chk("use_cnt", {28'd0, stall_cnt}, 32'd2); tick();

    // Hold a hazard long enough to saturate
    idle(); fs = 5'd3; ft = 5'd4; ft_use = 1'b1; e2w = 1'b1; e2n = 5'd4;
    for (int i = 0; i < 20; i++) begin
      settle(); tick();
    end
    settle(); chk("sat_cnt", {28'd0, stall_cnt}, 32'd15);

    // Reset asserted in the middle of the stall
    #1; clrn = 1'b1; #1;
    model_clear();
    chk("mid_cnt", {28'd0, stall_cnt}, 32'd0);
    chk("mid_a", a, 32'd0);
    chk("mid_stall", {31'd0, stall_fp}, 32'd1);
    tick();
    settle(); tick();
    clrn = 1'b0;

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      fs = 5'($urandom_range(0, 7)); ft = 5'($urandom_range(0, 7));
      fs_use = 1'($urandom_range(0, 1)); ft_use = 1'($urandom_range(0, 1));
      e1w = ($urandom_range(0, 3) == 0); e1n = 5'($urandom_range(0, 7));
      e2w = ($urandom_range(0, 3) == 0); e2n = 5'($urandom_range(0, 7));
      e3w = 1'($urandom_range(0, 1));   e3n = 5'($urandom_range(0, 7));
      ed  = $urandom;
      ww  = 1'($urandom_range(0, 1));   wn  = 5'($urandom_range(0, 31));
      wd  = $urandom;
      if (n == 200) begin
        #1; clrn = 1'b1; #1; model_clear(); #1; clrn = 1'b0;
      end
      settle();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
